// File: rtl/fc_layer_scheduler.sv
// Layer sequencer for the shared FC engine: per layer loads weights, starts the FC
// controller and tracks its output stream. Optional watchdog: define FC_SCHED_WDOG_EN.
module fc_layer_scheduler #(
    parameter int unsigned MAX_LAYERS = 4,
    parameter int unsigned WDOG_LIMIT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we_i,
    input  logic [1:0] cfg_layer_i,
    input  logic [6:0] cfg_in_node_i,
    input  logic [6:0] cfg_out_node_i,
    input  logic [1:0] cfg_num_layers_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] layer_idx_o,
    output logic       wload_req_o,
    output logic [1:0] wload_layer_o,
    input  logic       wload_done_i,
    output logic       ifmap_sel_o,
    output logic       fc_start_o,
    output logic [6:0] fc_in_node_o,
    output logic [6:0] fc_out_node_o,
    input  logic       fc_valid_i,
    input  logic       fc_last_i
);

    localparam int unsigned LW = 2;
    localparam int unsigned NW = 7;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WLOAD,
        S_START,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [LW-1:0]   nlay_q, nlay_d;
    logic            err_q, err_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [NW-1:0]   in_tbl_q  [MAX_LAYERS];
    logic [NW-1:0]   out_tbl_q [MAX_LAYERS];
    logic            cfg_bad;
    logic [BW-1:0]   beats_now;

`ifdef FC_SCHED_WDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_LIMIT + 1);
    logic [WDW-1:0]  wdog_q, wdog_d;
`endif

    // Any active layer with a zero node count makes the pass illegal
    always_comb begin
        cfg_bad = 1'b0;
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            if (LW'(i) <= nlay_q && (in_tbl_q[i] == '0 || out_tbl_q[i] == '0)) begin
                cfg_bad = 1'b1;
            end
        end
    end

    assign beats_now = beat_q + BW'(fc_valid_i);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        nlay_d  = nlay_q;
        err_d   = err_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nlay_d  = cfg_num_layers_i;
                    err_d   = 1'b0;
                    layer_d = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (wload_done_i) begin
                    beat_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                beat_d = beats_now;
                if (fc_last_i) begin
                    if (beats_now != BW'(out_tbl_q[layer_q])) begin
                        err_d = 1'b1;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (layer_q == nlay_q) begin
                    state_d = S_DONE;
                end else begin
                    layer_d = layer_q + LW'(1);
                    state_d = S_WLOAD;
                end
            end
            S_DONE: begin
                layer_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FC_SCHED_WDOG_EN
        // Idle-time counter; a stalled DMA or FC stream aborts the pass with an error
        wdog_d = (state_d != state_q || fc_valid_i) ? '0 : wdog_q + WDW'(1);
        if ((state_q == S_WLOAD || state_q == S_RUN) && state_d == state_q && !fc_valid_i
            && wdog_q == WDW'(WDOG_LIMIT - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            wdog_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            nlay_q  <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
`ifdef FC_SCHED_WDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            nlay_q  <= nlay_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
`ifdef FC_SCHED_WDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // Node-count table; writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
                in_tbl_q[i]  <= '0;
                out_tbl_q[i] <= '0;
            end
        end else if (state_q == S_IDLE && cfg_we_i) begin
            in_tbl_q[cfg_layer_i]  <= cfg_in_node_i;
            out_tbl_q[cfg_layer_i] <= cfg_out_node_i;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign layer_idx_o   = layer_q;
    assign wload_req_o   = (state_q == S_WLOAD);
    assign wload_layer_o = layer_q;
    assign ifmap_sel_o   = (layer_q != '0);
    assign fc_start_o    = (state_q == S_START);
    assign fc_in_node_o  = busy_o ? in_tbl_q[layer_q]  : '0;
    assign fc_out_node_o = busy_o ? out_tbl_q[layer_q] : '0;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Scoreboard bench for fc_layer_scheduler: expected wload/start/done events are queued
// from a table-level model and popped by an independent output monitor.
module tb_fc_layer_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we_i;
    logic [1:0] cfg_layer_i;
    logic [6:0] cfg_in_node_i;
    logic [6:0] cfg_out_node_i;
    logic [1:0] cfg_num_layers_i;
    logic       start_i;
    logic       busy_o, done_o, err_o;
    logic [1:0] layer_idx_o;
    logic       wload_req_o;
    logic [1:0] wload_layer_o;
    logic       wload_done_i;
    logic       ifmap_sel_o;
    logic       fc_start_o;
    logic [6:0] fc_in_node_o, fc_out_node_o;
    logic       fc_valid_i, fc_last_i;

    fc_layer_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_we_i         (cfg_we_i),
        .cfg_layer_i      (cfg_layer_i),
        .cfg_in_node_i    (cfg_in_node_i),
        .cfg_out_node_i   (cfg_out_node_i),
        .cfg_num_layers_i (cfg_num_layers_i),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .layer_idx_o      (layer_idx_o),
        .wload_req_o      (wload_req_o),
        .wload_layer_o    (wload_layer_o),
        .wload_done_i     (wload_done_i),
        .ifmap_sel_o      (ifmap_sel_o),
        .fc_start_o       (fc_start_o),
        .fc_in_node_o     (fc_in_node_o),
        .fc_out_node_o    (fc_out_node_o),
        .fc_valid_i       (fc_valid_i),
        .fc_last_i        (fc_last_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = weight-load request, 1 = FC start, 2 = done
        int layer;
        int inn;
        int outn;
        int err;
    } ev_t;

    ev_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  tin[4];
    int  tout[4];
    logic prev_wreq = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int layer, input int inn, input int outn, input int err);
        ev_t e;
        e.kind = kind; e.layer = layer; e.inn = inn; e.outn = outn; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = sb_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            0: begin
                chk("wload_layer", int'(wload_layer_o), e.layer);
                chk("wload_ifmap_sel", int'(ifmap_sel_o), int'(e.layer != 0));
            end
            1: begin
                chk("start_layer", int'(layer_idx_o), e.layer);
                chk("start_in_node", int'(fc_in_node_o), e.inn);
                chk("start_out_node", int'(fc_out_node_o), e.outn);
                chk("start_ifmap_sel", int'(ifmap_sel_o), int'(e.layer != 0));
            end
            default: begin
                chk("done_err", int'(err_o), e.err);
                chk("done_busy", int'(busy_o), 1);
            end
        endcase
    endtask

    // Output monitor, decoupled from the stimulus
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wreq = 1'b0;
        end else begin
            if (wload_req_o && !prev_wreq) handle(0);
            if (fc_start_o) handle(1);
            if (done_o) handle(2);
            prev_wreq = wload_req_o;
        end
    end

    task automatic write_tbl();
        for (int i = 0; i < 4; i++) begin
            cfg_we_i = 1'b1;
            cfg_layer_i = 2'(i);
            cfg_in_node_i = 7'(tin[i]);
            cfg_out_node_i = 7'(tout[i]);
            tick();
        end
        cfg_we_i = 1'b0;
    endtask

    task automatic run_pass(input int n, input bit wr, input bit poke, input int dly, input int beats[4]);
        bit bad;
        int e;
        int d;
        int cnt;
        if (wr) write_tbl();
        bad = 1'b0;
        for (int i = 0; i <= n; i++) if (tin[i] == 0 || tout[i] == 0) bad = 1'b1;
        if (bad) begin
            push(2, 0, 0, 0, 1);
        end else begin
            e = 0;
            for (int l = 0; l <= n; l++) begin
                push(0, l, 0, 0, 0);
                push(1, l, tin[l], tout[l], 0);
                if (beats[l] != tout[l]) e = 1;
            end
            push(2, 0, 0, 0, e);
        end
        cfg_num_layers_i = 2'(n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
        tick();
        if (bad) begin
            chk("check_done_latency", int'(done_o), 1);
            chk("check_no_wreq", int'(wload_req_o), 0);
            tick();
            chk("idle_after_check_err", int'(busy_o), 0);
            return;
        end
        chk("wreq_latency", int'(wload_req_o), 1);
        e = 0;
        for (int l = 0; l <= n; l++) begin
            d = (dly >= 0) ? dly : int'($urandom_range(0, 4));
            for (int k = 0; k < d; k++) begin
                fc_valid_i = 1'($urandom_range(0, 1));
                tick();
            end
            fc_valid_i = 1'b0;
            wload_done_i = 1'b1;
            tick();
            wload_done_i = 1'b0;
            chk("fc_start_after_wdone", int'(fc_start_o), 1);
            chk("wreq_drop_after_wdone", int'(wload_req_o), 0);
            tick();
            chk("fc_start_one_cycle", int'(fc_start_o), 0);
            if (poke && l == 0) begin
                cfg_we_i = 1'b1; cfg_layer_i = 2'd0;
                cfg_in_node_i = 7'd33; cfg_out_node_i = 7'd33;
                start_i = 1'b1; wload_done_i = 1'b1;
                tick();
                cfg_we_i = 1'b0; start_i = 1'b0; wload_done_i = 1'b0;
            end
            for (int k = 0; k < beats[l]; k++) begin
                cnt = int'($urandom_range(0, 2));
                for (int g = 0; g < cnt; g++) tick();
                fc_valid_i = 1'b1;
                fc_last_i = (k == beats[l] - 1);
                tick();
                fc_valid_i = 1'b0;
                fc_last_i = 1'b0;
            end
            if (beats[l] != tout[l]) e = 1;
            chk("err_after_last", int'(err_o), e);
            tick();
            if (l < n) chk("next_wreq_latency", int'(wload_req_o), 1);
            else       chk("done_latency", int'(done_o), 1);
        end
        tick();
        chk("idle_after_done", int'(busy_o), 0);
    endtask

    task automatic reset_check();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_wreq", int'(wload_req_o), 0);
        chk("rst_fc_start", int'(fc_start_o), 0);
        chk("rst_ifmap_sel", int'(ifmap_sel_o), 0);
        chk("rst_layer", int'(layer_idx_o), 0);
        chk("rst_wload_layer", int'(wload_layer_o), 0);
        chk("rst_in_node", int'(fc_in_node_o), 0);
        chk("rst_out_node", int'(fc_out_node_o), 0);
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin tin[i] = 0; tout[i] = 0; end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b[4];
        int n;
        int idx;
        int cnt;
        rst_n = 1'b0;
        cfg_we_i = 1'b0; cfg_layer_i = '0; cfg_in_node_i = '0; cfg_out_node_i = '0;
        cfg_num_layers_i = '0; start_i = 1'b0; wload_done_i = 1'b0;
        fc_valid_i = 1'b0; fc_last_i = 1'b0;
        tick();
        reset_check();

        // Two-layer 120->84->10 pass
        tin = '{120, 84, 0, 0}; tout = '{84, 10, 0, 0};
        b = '{84, 10, 0, 0};
        run_pass(1, 1'b1, 1'b0, 5, b);

        // Short output stream on a single layer
        tin = '{16, 84, 0, 0}; tout = '{8, 10, 0, 0};
        b = '{7, 0, 0, 0};
        run_pass(0, 1'b1, 1'b0, -1, b);

        // Zero output count on an active entry
        tout[1] = 0;
        b = '{8, 0, 0, 0};
        run_pass(1, 1'b1, 1'b0, -1, b);

        // Config and start poked during RUN, then reused table without rewrite
        tin = '{50, 20, 0, 0}; tout = '{30, 12, 0, 0};
        b = '{30, 12, 0, 0};
        run_pass(1, 1'b1, 1'b1, -1, b);
        run_pass(1, 1'b0, 1'b0, -1, b);

        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                tin[i] = int'($urandom_range(1, 127));
                tout[i] = int'($urandom_range(1, 84));
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) tin[idx] = 0;
                else tout[idx] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                b[i] = tout[i] == 0 ? 1 : tout[i];
                if ($urandom_range(0, 4) == 0) b[i] = (b[i] > 1) ? b[i] - 1 : b[i] + 1;
            end
            run_pass(n, 1'b1, 1'b0, -1, b);
        end

        // Weight load that never completes
        tin = '{10, 0, 0, 0}; tout = '{5, 0, 0, 0};
        write_tbl();
        push(0, 0, 0, 0, 0);
`ifdef FC_SCHED_WDOG_EN
        push(2, 0, 0, 0, 1);
`endif
        cfg_num_layers_i = 2'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("stall_wreq", int'(wload_req_o), 1);
`ifdef FC_SCHED_WDOG_EN
        cnt = 0;
        while (busy_o && cnt < 1100) begin tick(); cnt++; end
        chk("wdog_abort", int'(busy_o), 0);
`else
        repeat (1100) tick();
        chk("stall_still_wload", int'(wload_req_o), 1);
        chk("stall_still_busy", int'(busy_o), 1);
`endif
        reset_check();

        // Reset mid-WLOAD, then table must read back as cleared
        tin = '{40, 0, 0, 0}; tout = '{20, 0, 0, 0};
        write_tbl();
        push(0, 0, 0, 0, 0);
        cfg_num_layers_i = 2'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("mid_wload_wreq", int'(wload_req_o), 1);
        reset_check();
        b = '{1, 1, 1, 1};
        run_pass(0, 1'b0, 1'b0, -1, b);

        repeat (3) tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
